// File: rtl/booth_sched_pkg.sv
// Shared definitions for the Booth multiplier scheduler: default widths,
// multiplier latency, the tag carried alongside each product, and clog2.
package booth_sched_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_A_W        = 8;
    localparam int DEF_B_W        = 8;
    localparam int DEF_MUL_LAT    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // Wide enough for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                v;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/booth_sched_fifo.sv
// Result FIFO for the Booth scheduler: pointer-plus-count synchronous FIFO,
// simultaneous write and pop honoured in every state, no bypass path.
module booth_sched_fifo
    import booth_sched_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_rd;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; count gates every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must make a write into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!resetn)
        !(wr_en && !do_rd && count == FULL_CNT));

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one pipelined Booth multiplier among NUM_REQ
// requesters. Define BOOTH_SCHED_STATS_EN to add issue/stall counters.
module booth_mul_sched
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int A_W        = DEF_A_W,
    parameter int B_W        = DEF_B_W,
    parameter int P_W        = A_W + B_W - 1,
    parameter int MUL_LAT    = DEF_MUL_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ID_W       = clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_W-1:0]     req_a,
    input  logic [NUM_REQ*B_W-1:0]     req_b,
    output logic [A_W-1:0]             mul_a,
    output logic [B_W-1:0]             mul_b,
    input  logic [P_W-1:0]             mul_p,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [P_W-1:0]             rsp_p,
    output logic [clog2(FIFO_DEPTH):0] occ
`ifdef BOOTH_SCHED_STATS_EN
    ,
    output logic [15:0]                stat_issue,
    output logic [15:0]                stat_stall
`endif
);

    localparam int OCC_W = clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_DEPTH);
    localparam int FW = ID_W + P_W;

    logic [ID_W-1:0] ptr, gnt, cand;
    logic            found, credit, issue, pop;
    tag_t            tag_q [MUL_LAT];
    logic [FW-1:0]   head;
    logic            fifo_empty;

    // NOTE: blocking assignments in always_comb, every output defaulted first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    assign credit = (occ < OCC_MAX);
    assign issue  = resetn && found && credit;
    assign pop    = rsp_valid && rsp_ready;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (issue) begin
            req_ready[gnt] = 1'b1;
            mul_a          = req_a[int'(gnt)*A_W +: A_W];
            mul_b          = req_b[int'(gnt)*B_W +: B_W];
        end
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
    end

    // Tag pipe mirrors the multiplier latency so the id lines up with mul_p.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= '{v: issue, id: MAX_ID_W'(gnt)};
            for (int k = 1; k < MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    booth_sched_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (tag_q[MUL_LAT-1].v),
        .wr_data ({ID_W'(tag_q[MUL_LAT-1].id), mul_p}),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    assign rsp_valid       = !fifo_empty;
    assign {rsp_id, rsp_p} = fifo_empty ? '0 : head;

`ifdef BOOTH_SCHED_STATS_EN
    logic stall;
    assign stall = (|req_valid) && !credit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (issue && stat_issue != 16'hFFFF) stat_issue <= stat_issue + 1'b1;
            if (stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
// Randomized scoreboard bench for booth_mul_sched with a behavioural
// multiplier, arbitration/credit reference model and in-order result queue.
module tb_booth_mul_sched;

    localparam int N     = 4;
    localparam int AW    = 8;
    localparam int BW    = 8;
    localparam int PW    = AW + BW - 1;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic [AW-1:0]     mul_a;
    logic [BW-1:0]     mul_b;
    logic [PW-1:0]     mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_p;
    logic [2:0]        occ;

    booth_mul_sched #(
        .NUM_REQ    (N),
        .A_W        (AW),
        .B_W        (BW),
        .MUL_LAT    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic signed [AW+BW-1:0] p;
        p = $signed(a) * $signed(b);
        return p[PW-1:0];
    endfunction

    // External multiplier: LAT register stages from the operand capture edge.
    logic [PW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) mpipe[k] <= mpipe[k-1];
        mpipe[0] <= ref_prod(mul_a, mul_b);
    end
    assign mul_p = mpipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic [PW-1:0] p;
        int            rc;
    } exp_t;

    exp_t sb [$];
    int   gcnt [N];

    // Reference model: credit count, rotating priority pointer, expected grants.
    int          m_occ = 0;
    int          m_ptr = 0;
    int          m_g;
    int          c_idx;
    bit          m_issue;
    logic [N-1:0] exp_rdy;
    exp_t        e_new;

    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_p", rsp_p, 0);
            check("rst_occ", occ, 0);
            check("rst_mul_ab", {mul_a, mul_b}, 0);
            sb.delete();
            m_occ = 0;
            m_ptr = 0;
        end else begin
            check("occ", occ, m_occ);
            m_issue = 1'b0;
            m_g     = 0;
            exp_rdy = '0;
            if (m_occ < DEPTH) begin
                for (int k = 0; k < N; k++) begin
                    c_idx = (m_ptr + k) % N;
                    if (!m_issue && req_valid[c_idx]) begin
                        m_issue = 1'b1;
                        m_g     = c_idx;
                    end
                end
            end
            if (m_issue) exp_rdy[m_g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            if (m_issue) begin
                check("mul_a", mul_a, req_a[m_g*AW +: AW]);
                check("mul_b", mul_b, req_b[m_g*BW +: BW]);
                e_new.id = m_g;
                e_new.p  = ref_prod(req_a[m_g*AW +: AW], req_b[m_g*BW +: BW]);
                e_new.rc = cyc + LAT + 1;
                sb.push_back(e_new);
                gcnt[m_g]++;
                m_ptr = (m_g + 1) % N;
                m_occ++;
            end else begin
                check("mul_idle", {mul_a, mul_b}, 0);
            end
            if (rsp_valid && rsp_ready) m_occ--;
        end
    end

    // Monitor: a result is due LAT+1 cycles after issue and leaves in issue order.
    exp_t e_pop;
    bit   exp_v;
    always @(negedge clk) begin
        if (resetn) begin
            exp_v = (sb.size() > 0) && (sb[0].rc <= cyc);
            check("rsp_valid", rsp_valid, exp_v);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e_pop = sb.pop_front();
                    check("rsp_id", rsp_id, e_pop.id);
                    check("rsp_p", rsp_p, e_pop.p);
                end
            end
        end
    end

    logic [N-1:0] last_hs;

    // One clock of requester/consumer behaviour; entered and left at posedge+1.
    task automatic step(input int pct, input int mode);
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && int'($urandom_range(99)) < pct) begin
                req_valid[i]         = 1'b1;
                req_a[i*AW +: AW]    = AW'($urandom);
                req_b[i*BW +: BW]    = BW'($urandom);
            end
        end
        case (mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            2:       rsp_ready = !rsp_ready;
            default: rsp_ready = 1'($urandom_range(1));
        endcase
        @(negedge clk);
        last_hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_hs;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_valid[i]      = 1'b1;
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
    endtask

    task automatic drain();
        int n = 0;
        while ((req_valid != '0 || sb.size() != 0) && n < 300) begin
            step(0, 1);
            n++;
        end
        check("drain_sb", sb.size(), 0);
        check("drain_occ", occ, 0);
    endtask

    function automatic int issued();
        int s = 0;
        for (int i = 0; i < N; i++) s += gcnt[i];
        return s;
    endfunction

    task automatic clear_gcnt();
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    int lat;
    int mn, mx;

    initial begin
        resetn    = 1'b0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_valid = '1;
        for (int k = 0; k < LAT; k++) mpipe[k] = '0;
        clear_gcnt();
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        resetn    = 1'b1;

        // Single request: 7*6 from requester 0, MUL_LAT+1 latency.
        rsp_ready = 1'b1;
        set_req(0, 8'd7, 8'd6);
        step(0, 1);
        check("single_hs", last_hs, 4'b0001);
        wait_rsp(lat);
        check("single_lat", lat, LAT + 1);
        check("single_id", rsp_id, 0);
        check("single_p", rsp_p, 15'd42);
        @(posedge clk);
        #1;

        // Signed product from requester 2.
        set_req(2, 8'hFD, 8'h05);
        step(0, 1);
        check("signed_hs", last_hs, 4'b0100);
        wait_rsp(lat);
        check("signed_lat", lat, LAT + 1);
        check("signed_id", rsp_id, 2);
        check("signed_p", rsp_p, 15'h7FF1);
        @(posedge clk);
        #1;

        // Round robin with every requester permanently valid.
        clear_gcnt();
        repeat (40) step(100, 1);
        mn = gcnt[0];
        mx = gcnt[0];
        for (int i = 1; i < N; i++) begin
            if (gcnt[i] < mn) mn = gcnt[i];
            if (gcnt[i] > mx) mx = gcnt[i];
        end
        check("rr_fair", (mx - mn) <= 1, 1);
        check("rr_progress", issued() >= 8, 1);
        drain();

        // Credit exhaustion with the consumer stalled.
        clear_gcnt();
        repeat (12) step(100, 0);
        check("credit_issues", issued(), DEPTH);
        check("credit_occ", occ, DEPTH);
        check("credit_ready", req_ready, 0);
        step(100, 1);
        check("credit_pop_occ", occ, DEPTH - 1);
        check("credit_pop_noissue", issued(), DEPTH);
        step(100, 0);
        check("credit_reissue", issued(), DEPTH + 1);
        check("credit_refill_occ", occ, DEPTH);
        drain();

        // Reset with three products in flight.
        clear_gcnt();
        set_req(0, AW'($urandom), BW'($urandom));
        set_req(1, AW'($urandom), BW'($urandom));
        set_req(2, AW'($urandom), BW'($urandom));
        repeat (3) step(0, 1);
        check("midrst_issues", issued(), 3);
        repeat (2) step(0, 1);
        resetn = 1'b0;
        step(0, 1);
        resetn = 1'b1;
        check("midrst_occ", occ, 0);
        repeat (12) begin
            step(0, 1);
            check("midrst_no_rsp", rsp_valid, 0);
        end
        for (int i = 0; i < N; i++) set_req(i, AW'($urandom), BW'($urandom));
        step(0, 1);
        check("midrst_ptr0", last_hs, 4'b0001);
        drain();

        // Full FIFO with write and pop coinciding while rsp_ready toggles.
        repeat (60) step(100, 2);
        drain();

        // Random traffic and random backpressure.
        repeat (300) step(50, 3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
